// File: rtl/des_key_schedule.sv
// DES key schedule: turns the 56-bit PC-1 output into round subkeys K1..K16.
// One subkey is presented per output handshake. C/D are rotated in place and
// PC-2 is pure wiring from the C/D flops to the subkey port.
// Optional build macro DES_KS_DECRYPT_EN adds a `decrypt` input that, when set
// at key accept, emits K16..K1 by right-rotating instead.
module des_key_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic [0:55]  kplus,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [0:47]  subkey,
    output logic [4:0]   sk_round,
    output logic         sk_valid,
    input  logic         sk_ready,
    output logic         done
`ifdef DES_KS_DECRYPT_EN
    ,
    input  logic         decrypt
`endif
);

    localparam int unsigned HALF_W = 28;
    localparam int unsigned CD_W   = 56;
    localparam int unsigned SK_W   = 48;
    localparam int unsigned RND_W  = 5;

    localparam logic [RND_W-1:0] FIRST_RND = RND_W'(1);
    localparam logic [RND_W-1:0] LAST_RND  = RND_W'(16);

    // PC-2 selection table, 1-based positions into CD
    localparam int unsigned PC2 [SK_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Rotation amount used to produce the subkey of the given round
    function automatic logic [1:0] shift_of(input logic [RND_W-1:0] rnd);
        case (rnd)
            RND_W'(1), RND_W'(2), RND_W'(9), RND_W'(16): shift_of = 2'd1;
            default:                                     shift_of = 2'd2;
        endcase
    endfunction

    function automatic logic [0:HALF_W-1] rotl(input logic [0:HALF_W-1] h,
                                                input logic [1:0]        n);
        rotl = (n == 2'd1) ? {h[1:HALF_W-1], h[0]} : {h[2:HALF_W-1], h[0:1]};
    endfunction

`ifdef DES_KS_DECRYPT_EN
    function automatic logic [0:HALF_W-1] rotr(input logic [0:HALF_W-1] h,
                                                input logic [1:0]        n);
        rotr = (n == 2'd1) ? {h[HALF_W-1], h[0:HALF_W-2]}
                           : {h[HALF_W-2:HALF_W-1], h[0:HALF_W-3]};
    endfunction
`endif

    state_e            state_q, state_d;
    logic [0:HALF_W-1] c_q, c_d;
    logic [0:HALF_W-1] d_q, d_d;
    logic [RND_W-1:0]  round_q, round_d;
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic [RND_W-1:0]  final_rnd;
    logic [0:CD_W-1]   cd;

`ifdef DES_KS_DECRYPT_EN
    logic              dec_q, dec_d;
    assign final_rnd = dec_q ? FIRST_RND : LAST_RND;
`else
    assign final_rnd = LAST_RND;
`endif

    // Next-state, rotation and handshake control
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        valid_d = valid_q;
        ready_d = ready_q;
        done_d  = 1'b0;
`ifdef DES_KS_DECRYPT_EN
        dec_d   = dec_q;
`endif
        case (state_q)
            IDLE: begin
                if (key_valid && ready_q) begin
`ifdef DES_KS_DECRYPT_EN
                    dec_d = decrypt;
                    if (decrypt) begin
                        // C16D16 equals C0D0: start from the unrotated key
                        c_d     = kplus[0:HALF_W-1];
                        d_d     = kplus[HALF_W:CD_W-1];
                        round_d = LAST_RND;
                    end else begin
                        c_d     = rotl(kplus[0:HALF_W-1], 2'd1);
                        d_d     = rotl(kplus[HALF_W:CD_W-1], 2'd1);
                        round_d = FIRST_RND;
                    end
`else
                    c_d     = rotl(kplus[0:HALF_W-1], 2'd1);
                    d_d     = rotl(kplus[HALF_W:CD_W-1], 2'd1);
                    round_d = FIRST_RND;
`endif
                    valid_d = 1'b1;
                    ready_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (valid_q && sk_ready) begin
                    if (round_q == final_rnd) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end
`ifdef DES_KS_DECRYPT_EN
                    else if (dec_q) begin
                        c_d     = rotr(c_q, shift_of(round_q));
                        d_d     = rotr(d_q, shift_of(round_q));
                        round_d = RND_W'(round_q - RND_W'(1));
                    end
`endif
                    else begin
                        c_d     = rotl(c_q, shift_of(RND_W'(round_q + RND_W'(1))));
                        d_d     = rotl(d_q, shift_of(RND_W'(round_q + RND_W'(1))));
                        round_d = RND_W'(round_q + RND_W'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
`ifdef DES_KS_DECRYPT_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            done_q  <= done_d;
`ifdef DES_KS_DECRYPT_EN
            dec_q   <= dec_d;
`endif
        end
    end

    assign cd = {c_q, d_q};

    // PC-2 is a fixed permutation: no logic between the C/D flops and subkey
    for (genvar i = 0; i < SK_W; i++) begin : g_pc2
        assign subkey[i] = cd[PC2[i] - 1];
    end

    assign key_ready = ready_q;
    assign sk_round  = round_q;
    assign sk_valid  = valid_q;
    assign done      = done_q;

endmodule
